// File: rtl/mips8_dbg_pkg.sv
// Shared types and helpers for the MIPS8 debug dump sequencer.
// Holds the FSM state encoding, default scan depths and the item-index decode.
package mips8_dbg_pkg;

  localparam int RF_DEPTH_DEFAULT = 4;
  localparam int DM_DEPTH_DEFAULT = 16;
  localparam int IDX_W = $clog2(RF_DEPTH_DEFAULT + DM_DEPTH_DEFAULT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ARM,
    ST_RUN,
    ST_READ,
    ST_SEND,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic       is_dm;
    logic [3:0] addr;
  } dbg_sel_t;

  // Items below rf_base are register-file entries; the rest map onto data memory.
  function automatic dbg_sel_t idx_decode(input logic [IDX_W-1:0] idx,
                                          input logic [IDX_W-1:0] rf_base);
    dbg_sel_t sel;
    sel.is_dm = (idx >= rf_base);
    sel.addr  = sel.is_dm ? 4'(idx - rf_base) : 4'(idx);
    return sel;
  endfunction

endpackage

// File: rtl/mips8_dump_sequencer_run_watchdog.sv
// Saturating cycle counter bounding one CPU run.
// expired is asserted while enabled and the count sits at MAX_RUN_CYCLES-1.
module run_watchdog #(
  parameter int MAX_RUN_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(MAX_RUN_CYCLES);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_RUN_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Stops at LIMIT so a long stall can never wrap back to a small count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/mips8_dump_sequencer.sv
// Run-and-dump controller: starts the CPU, waits for halt or watchdog, then
// streams every RF entry and DM byte as tagged items on a valid/ready port.
module mips8_dump_sequencer
  import mips8_dbg_pkg::*;
#(
  parameter int RF_DEPTH       = RF_DEPTH_DEFAULT,
  parameter int DM_DEPTH       = DM_DEPTH_DEFAULT,
  parameter int DATA_W         = 8,
  parameter int MAX_RUN_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  output logic              busy,
  output logic              done,
  output logic              timed_out,
  output logic              cpu_start,
  input  logic              cpu_stopped,
  output logic              dbg_is_dm,
  output logic [3:0]        dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_is_dm,
  output logic [3:0]        out_addr,
  output logic              out_last
);

  localparam logic [IDX_W-1:0] RF_BASE  = IDX_W'(RF_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RF_DEPTH + DM_DEPTH - 1);

  state_t           state, next_state;
  logic [IDX_W-1:0] item_idx;
  logic             wd_clear, wd_enable, wd_expired, timeout_hit;
  dbg_sel_t         sel;

  // The debug port follows the index register, so it holds its last value outside READ.
  assign sel       = idx_decode(item_idx, RF_BASE);
  assign dbg_is_dm = sel.is_dm;
  assign dbg_addr  = sel.addr;

  assign wd_clear  = (state == ST_IDLE) && go;
  assign wd_enable = (state == ST_ARM) || (state == ST_RUN);

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign cpu_start = (state == ST_START);
  assign out_valid = (state == ST_SEND);

  run_watchdog #(
    .MAX_RUN_CYCLES(MAX_RUN_CYCLES)
  ) u_run_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // ARM only exits on a falling halt flag, so a CPU stuck in halt runs into the watchdog.
  always_comb begin
    next_state  = state;
    timeout_hit = 1'b0;
    unique case (state)
      ST_IDLE:  if (go) next_state = ST_START;
      ST_START: next_state = ST_ARM;
      ST_ARM: begin
        if (!cpu_stopped) begin
          next_state = ST_RUN;
        end else if (wd_expired) begin
          next_state  = ST_READ;
          timeout_hit = 1'b1;
        end
      end
      ST_RUN: begin
        if (cpu_stopped) begin
          next_state = ST_READ;
        end else if (wd_expired) begin
          next_state  = ST_READ;
          timeout_hit = 1'b1;
        end
      end
      ST_READ:  next_state = ST_SEND;
      ST_SEND:  if (out_ready) next_state = out_last ? ST_DONE : ST_READ;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timed_out <= 1'b0;
      item_idx  <= '0;
      out_data  <= '0;
      out_is_dm <= 1'b0;
      out_addr  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (wd_clear)         timed_out <= 1'b0;
      else if (timeout_hit) timed_out <= 1'b1;

      if (wd_enable && (next_state == ST_READ)) begin
        item_idx <= '0;
      end else if ((state == ST_SEND) && out_ready && !out_last) begin
        item_idx <= item_idx + IDX_W'(1);
      end

      // Captured once per item; held untouched for the whole SEND stall.
      if (state == ST_READ) begin
        out_data  <= dbg_data;
        out_is_dm <= sel.is_dm;
        out_addr  <= sel.addr;
        out_last  <= (item_idx == LAST_IDX);
      end
    end
  end

endmodule

// File: tb/tb_mips8_dump_sequencer.sv
// Self-checking bench for mips8_dump_sequencer with a small CPU/memory model
// and a reference item list built directly from the memory contents.
module tb_mips8_dump_sequencer;

  localparam int N_ITEMS = 20;
  localparam int WD      = 64;
  localparam int CPU_NORMAL = 0, CPU_NEVER = 1, CPU_STUCK = 2;

  typedef struct packed {
    logic [7:0] data;
    logic       is_dm;
    logic [3:0] addr;
    logic       last;
  } item_t;

  logic       clk = 1'b0;
  logic       rst_n, go, cpu_stopped, out_ready;
  logic       busy, done, timed_out, cpu_start, dbg_is_dm, out_valid, out_is_dm, out_last;
  logic [3:0] dbg_addr, out_addr;
  logic [7:0] dbg_data, out_data;

  logic [7:0] rf [4];
  logic [7:0] dm [16];

  int    checks = 0, errors = 0, cyc = 0;
  item_t got_q[$];
  item_t cur_item, prev_item;
  bit    prev_stall = 0, valid_seen = 0;
  int    stall_err = 0, overlap_err = 0, done_cnt = 0, done_cyc = 0, first_valid_cyc = 0;
  int    start_pulses = 0, start_cyc = 0, stop_cyc = 0;
  int    cpu_mode = CPU_NORMAL, stop_after = 50;
  int    ready_mode = 1, ready_limit = 1 << 30;

  mips8_dump_sequencer #(.MAX_RUN_CYCLES(WD)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .busy(busy), .done(done), .timed_out(timed_out),
    .cpu_start(cpu_start), .cpu_stopped(cpu_stopped), .dbg_is_dm(dbg_is_dm),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_is_dm(out_is_dm), .out_addr(out_addr), .out_last(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign dbg_data = dbg_is_dm ? dm[dbg_addr] : rf[dbg_addr[1:0]];
  assign cur_item = {out_data, out_is_dm, out_addr, out_last};

  // CPU model: leaves halt the cycle after cpu_start, halts again per cpu_mode.
  initial begin
    bit launch, running;
    int run_left;
    launch = 0; running = 0; run_left = 0;
    cpu_stopped = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (done) begin cpu_stopped = 1'b1; running = 0; end
      if (cpu_start) begin
        start_pulses++; start_cyc = cyc; launch = 1;
      end else if (launch) begin
        launch = 0;
        if (cpu_mode != CPU_STUCK) cpu_stopped = 1'b0;
        running  = (cpu_mode == CPU_NORMAL);
        run_left = stop_after;
      end else if (running) begin
        run_left--;
        if (run_left <= 0) begin running = 0; cpu_stopped = 1'b1; stop_cyc = cyc; end
      end
    end
  end

  initial begin
    bit r;
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 1)      r = 1;
      else if (ready_mode == 2) r = ($urandom_range(0, 99) < 30);
      else                      r = 0;
      out_ready = r && (got_q.size() < ready_limit);
    end
  end

  // Passive monitor: records accepted items and protocol observations.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall && (!out_valid || cur_item !== prev_item)) stall_err++;
      if (cpu_start) valid_seen = 0;
      if (out_valid && !valid_seen) begin valid_seen = 1; first_valid_cyc = cyc; end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (done && out_valid) overlap_err++;
      if (out_valid && out_ready) got_q.push_back(cur_item);
      prev_stall = out_valid && !out_ready;
      prev_item  = cur_item;
    end
  end

  function automatic item_t exp_item(int i);
    item_t e;
    if (i < 4) begin e.data = rf[i];     e.is_dm = 1'b0; e.addr = 4'(i);     end
    else       begin e.data = dm[i - 4]; e.is_dm = 1'b1; e.addr = 4'(i - 4); end
    e.last = (i == N_ITEMS - 1);
    return e;
  endfunction

  task automatic randomize_memories();
    foreach (rf[i]) rf[i] = 8'($urandom);
    foreach (dm[i]) dm[i] = 8'($urandom);
  endtask

  task automatic pulse_go();
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
  endtask

  task automatic wait_done(input int base_done, input int budget, output bit ok);
    ok = 0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk); #1;
      if (done_cnt > base_done) ok = 1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; go = 1'b0;
    #12;
    checks++;
    if ({busy, done, timed_out, cpu_start, out_valid} !== 5'b0) begin
      errors++; $display("[TB] FAIL reset_ctrl got %b want 00000", {busy, done, timed_out, cpu_start, out_valid});
    end
    checks++;
    if ({dbg_is_dm, dbg_addr} !== 5'b0) begin
      errors++; $display("[TB] FAIL reset_dbg got %b want 00000", {dbg_is_dm, dbg_addr});
    end
    checks++;
    if (cur_item !== '0) begin
      errors++; $display("[TB] FAIL reset_out got %h want 0", cur_item);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_normal_run();
    int base, bd, bs;
    bit ok;
    foreach (rf[i]) rf[i] = 8'(i + 1);
    foreach (dm[i]) dm[i] = 8'(8'h10 + i);
    cpu_mode = CPU_NORMAL; stop_after = 50; ready_mode = 1;
    base = got_q.size(); bd = done_cnt; bs = start_pulses;
    pulse_go();
    wait_done(bd, 400, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL normal_done got timeout want done"); end
    checks++;
    if (got_q.size() - base != N_ITEMS) begin
      errors++; $display("[TB] FAIL normal_count got %0d want %0d", got_q.size() - base, N_ITEMS);
    end
    for (int i = 0; i < N_ITEMS && base + i < got_q.size(); i++) begin
      checks++;
      if (got_q[base + i] !== exp_item(i)) begin
        errors++; $display("[TB] FAIL normal_item%0d got %h want %h", i, got_q[base + i], exp_item(i));
      end
    end
    checks++;
    if (done_cyc - stop_cyc != 41) begin
      errors++; $display("[TB] FAIL normal_done_latency got %0d want 41", done_cyc - stop_cyc);
    end
    checks++;
    if (first_valid_cyc - stop_cyc != 2) begin
      errors++; $display("[TB] FAIL normal_first_valid got %0d want 2", first_valid_cyc - stop_cyc);
    end
    checks++;
    if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL normal_timed_out got %b want 0", timed_out); end
    checks++;
    if (start_pulses - bs != 1) begin
      errors++; $display("[TB] FAIL normal_start_pulses got %0d want 1", start_pulses - bs);
    end
  endtask

  task automatic test_backpressure();
    int base, bd, bstall, bover;
    bit ok;
    randomize_memories();
    cpu_mode = CPU_NORMAL; stop_after = 20 + int'($urandom_range(0, 20)); ready_mode = 2;
    base = got_q.size(); bd = done_cnt; bstall = stall_err; bover = overlap_err;
    pulse_go();
    wait_done(bd, 3000, ok);
    ready_mode = 1;
    checks++; if (!ok) begin errors++; $display("[TB] FAIL bp_done got timeout want done"); end
    checks++;
    if (got_q.size() - base != N_ITEMS) begin
      errors++; $display("[TB] FAIL bp_count got %0d want %0d", got_q.size() - base, N_ITEMS);
    end
    for (int i = 0; i < N_ITEMS && base + i < got_q.size(); i++) begin
      checks++;
      if (got_q[base + i] !== exp_item(i)) begin
        errors++; $display("[TB] FAIL bp_item%0d got %h want %h", i, got_q[base + i], exp_item(i));
      end
    end
    checks++;
    if (stall_err != bstall) begin errors++; $display("[TB] FAIL bp_stable got %0d want 0", stall_err - bstall); end
    checks++;
    if (overlap_err != bover) begin errors++; $display("[TB] FAIL bp_overlap got %0d want 0", overlap_err - bover); end
  endtask

  task automatic test_timeout(input int mode, input string tag);
    int base, bd;
    bit ok;
    randomize_memories();
    cpu_mode = mode; ready_mode = 1;
    base = got_q.size(); bd = done_cnt;
    pulse_go();
    wait_done(bd, 400, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL %s_done got timeout want done", tag); end
    checks++;
    if (first_valid_cyc - start_cyc != WD + 2) begin
      errors++; $display("[TB] FAIL %s_read_entry got %0d want %0d", tag, first_valid_cyc - start_cyc, WD + 2);
    end
    checks++;
    if (timed_out !== 1'b1) begin errors++; $display("[TB] FAIL %s_timed_out got %b want 1", tag, timed_out); end
    checks++;
    if (got_q.size() - base != N_ITEMS) begin
      errors++; $display("[TB] FAIL %s_count got %0d want %0d", tag, got_q.size() - base, N_ITEMS);
    end
    for (int i = 0; i < N_ITEMS && base + i < got_q.size(); i++) begin
      checks++;
      if (got_q[base + i] !== exp_item(i)) begin
        errors++; $display("[TB] FAIL %s_item%0d got %h want %h", tag, i, got_q[base + i], exp_item(i));
      end
    end
  endtask

  task automatic test_go_while_busy();
    int base, bd, bs;
    bit ok, hit;
    randomize_memories();
    cpu_mode = CPU_NORMAL; stop_after = 50; ready_mode = 1;
    base = got_q.size(); bd = done_cnt; bs = start_pulses;
    pulse_go();
    checks++;
    if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL busy_timed_out_clear got %b want 0", timed_out); end
    repeat (20) @(posedge clk);
    pulse_go();
    hit = 0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin hit = 1; go = 1'b1; @(posedge clk); #1 go = 1'b0; end
    end
    checks++; if (!hit) begin errors++; $display("[TB] FAIL busy_send_seen got timeout want valid"); end
    wait_done(bd, 400, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL busy_done got timeout want done"); end
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_idle_after got %b want 0", busy); end
    checks++;
    if (start_pulses - bs != 1) begin
      errors++; $display("[TB] FAIL busy_start_pulses got %0d want 1", start_pulses - bs);
    end
    checks++;
    if (got_q.size() - base != N_ITEMS) begin
      errors++; $display("[TB] FAIL busy_count got %0d want %0d", got_q.size() - base, N_ITEMS);
    end
  endtask

  task automatic test_reset_mid_dump();
    int base, bd;
    bit ok, hit;
    randomize_memories();
    cpu_mode = CPU_NORMAL; stop_after = 30; ready_mode = 1;
    base = got_q.size(); ready_limit = base + 7;
    pulse_go();
    hit = 0;
    for (int n = 0; n < 300 && !hit; n++) begin
      @(negedge clk); #1;
      if (got_q.size() == base + 7 && out_valid) hit = 1;
    end
    checks++; if (!hit) begin errors++; $display("[TB] FAIL mid_item7_send got timeout want stall"); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, timed_out, cpu_start, out_valid} !== 5'b0) begin
      errors++; $display("[TB] FAIL mid_reset_ctrl got %b want 00000", {busy, done, timed_out, cpu_start, out_valid});
    end
    checks++;
    if ({dbg_is_dm, dbg_addr, cur_item} !== '0) begin
      errors++; $display("[TB] FAIL mid_reset_out got %h want 0", {dbg_is_dm, dbg_addr, cur_item});
    end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1; ready_limit = 1 << 30;
    @(negedge clk);
    base = got_q.size(); bd = done_cnt;
    pulse_go();
    wait_done(bd, 400, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL mid_redump_done got timeout want done"); end
    checks++;
    if (got_q.size() - base != N_ITEMS) begin
      errors++; $display("[TB] FAIL mid_redump_count got %0d want %0d", got_q.size() - base, N_ITEMS);
    end
    for (int i = 0; i < N_ITEMS && base + i < got_q.size(); i++) begin
      checks++;
      if (got_q[base + i] !== exp_item(i)) begin
        errors++; $display("[TB] FAIL mid_item%0d got %h want %h", i, got_q[base + i], exp_item(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal_run();
    test_backpressure();
    test_timeout(CPU_NEVER, "watchdog");
    test_timeout(CPU_STUCK, "stuck");
    test_go_while_busy();
    test_reset_mid_dump();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout got expired want finish");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
